// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the EX-stage mult/div unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

    // Controller state encoding, shared with the mult/div unit
    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    // Default EX-occupancy of multi-cycle operations
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    // Countdown width; 63 is the largest occupancy, so it never wraps
    localparam int CNT_W = 6;

    // Width of the saturating stall counter
    localparam int STALL_W = 16;

endpackage

// File: rtl/hazard_ctrl_md.sv
// Countdown for multi-cycle operations: load a start value, decrement to zero, flag zero.
// Latency: load and decrement take effect at the next rising edge; zero is decoded from the register.
// Backpressure: none; the controller decides when to load and when to decrement.
module md_counter
    import hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Count register: reset clears it, load has priority over decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch/jump flush, and front-end freeze while mult/div runs.
// Latency: control outputs are combinational (zero-latency); md_busy/md_done/stall_cnt come from registers.
// Backpressure: stalls the front end via pc_write/ifid_hold and feeds bubbles into ID/EX.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         rs_id,
    input  logic [4:0]         rt_id,
    input  logic               use_rs_id,
    input  logic               use_rt_id,
    input  logic               memread_ex,
    input  logic [4:0]         rt_ex,
    input  logic               md_id,
    input  logic               md_div_id,
    input  logic               branch_taken_ex,
    input  logic               jump_id,
    output logic               pc_write,
    output logic               ifid_hold,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               md_busy,
    output logic               md_done,
    output logic [STALL_W-1:0] stall_cnt
);

    // The counter starts at N-2 so that, counting the issue cycle, the
    // unit is occupied for exactly N cycles and the front end stalls N-1.
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 2);

    state_t state;
    state_t state_nxt;
    logic   lu;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    // Load-use: EX load writes a register the ID instruction reads ($0 never hazards)
    assign lu = memread_ex && (rt_ex != 5'd0) &&
                ((use_rs_id && (rs_id == rt_ex)) || (use_rt_id && (rt_id == rt_ex)));

    md_counter u_md_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (md_div_id ? DIV_LD : MUL_LD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control outputs; reset forces a flushed, frozen front end
    always_comb begin
        state_nxt   = state;
        pc_write    = 1'b1;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken_ex) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (lu) begin
                        pc_write    = 1'b0;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (jump_id) begin
                        ifid_flush  = 1'b1;
                    end else if (md_id) begin
                        cnt_load    = 1'b1;
                        state_nxt   = MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    pc_write    = 1'b0;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt_zero) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_dec   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    // Busy/done decode only from registers, so they are glitch-free to the EX unit
    assign md_busy = (state == MD_WAIT);
    assign md_done = (state == MD_WAIT) && cnt_zero;

    // Saturating count of cycles the PC was frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with default multiply/divide occupancies.
// Inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Each scenario task makes its own comparisons; summary line at the end.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_id, rt_id, rt_ex;
    logic        use_rs_id, use_rt_id, memread_ex;
    logic        md_id, md_div_id, branch_taken_ex, jump_id;
    logic        pc_write, ifid_hold, ifid_flush, idex_bubble;
    logic        md_busy, md_done;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_stall;

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .rs_id           (rs_id),
        .rt_id           (rt_id),
        .use_rs_id       (use_rs_id),
        .use_rt_id       (use_rt_id),
        .memread_ex      (memread_ex),
        .rt_ex           (rt_ex),
        .md_id           (md_id),
        .md_div_id       (md_div_id),
        .branch_taken_ex (branch_taken_ex),
        .jump_id         (jump_id),
        .pc_write        (pc_write),
        .ifid_hold       (ifid_hold),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs_id = 5'd0; rt_id = 5'd0; rt_ex = 5'd0;
        use_rs_id = 1'b0; use_rt_id = 1'b0; memread_ex = 1'b0;
        md_id = 1'b0; md_div_id = 1'b0; branch_taken_ex = 1'b0; jump_id = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0011", {pc_write, ifid_hold, ifid_flush, idex_bubble});
        end
        checks++;
        if ({md_busy, md_done, stall_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL reset_regs: busy=%b done=%b stall=%0h expected 0 0 0", md_busy, md_done, stall_cnt);
        end
        rst = 1'b0;
        exp_stall = 16'd0;
        #1;
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release: got %b expected 1000", {pc_write, ifid_hold, ifid_flush, idex_bubble});
        end
        step();
    endtask

    task automatic test_load_use();
        // rs match
        clear_inputs();
        memread_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble} !== 4'b0101) begin
            errors++;
            $display("FAIL lu_rs: got %b expected 0101", {pc_write, ifid_hold, ifid_flush, idex_bubble});
        end
        step();
        exp_stall = exp_stall + 16'd1;
        checks++;
        if (stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL lu_rs_stall: got %0d expected %0d", stall_cnt, exp_stall);
        end
        // rt match
        clear_inputs();
        memread_ex = 1'b1; rt_ex = 5'd17; rt_id = 5'd17; rs_id = 5'd3; use_rt_id = 1'b1; use_rs_id = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_hold, idex_bubble} !== 3'b011) begin
            errors++;
            $display("FAIL lu_rt: got %b expected 011", {pc_write, ifid_hold, idex_bubble});
        end
        step();
        exp_stall = exp_stall + 16'd1;
        // register matches but is not actually read
        clear_inputs();
        memread_ex = 1'b1; rt_ex = 5'd9; rs_id = 5'd9; rt_id = 5'd9;
        #1;
        checks++;
        if ({pc_write, ifid_hold, idex_bubble} !== 3'b100) begin
            errors++;
            $display("FAIL lu_unused: got %b expected 100", {pc_write, ifid_hold, idex_bubble});
        end
        step();
        // $0 destination never hazards
        clear_inputs();
        memread_ex = 1'b1; rt_ex = 5'd0; rs_id = 5'd0; use_rs_id = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble} !== 4'b1000) begin
            errors++;
            $display("FAIL lu_r0: got %b expected 1000", {pc_write, ifid_hold, ifid_flush, idex_bubble});
        end
        step();
        checks++;
        if (stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL lu_total_stall: got %0d expected %0d", stall_cnt, exp_stall);
        end
    endtask

    task automatic test_branch_priority();
        clear_inputs();
        branch_taken_ex = 1'b1; md_id = 1'b1; md_div_id = 1'b1;
        memread_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble} !== 4'b1011) begin
            errors++;
            $display("FAIL branch_prio: got %b expected 1011", {pc_write, ifid_hold, ifid_flush, idex_bubble});
        end
        step();
        clear_inputs();
        #1;
        checks++;
        if ({md_busy, pc_write} !== 2'b01) begin
            errors++;
            $display("FAIL branch_stays_run: busy=%b pc_write=%b expected 0 1", md_busy, pc_write);
        end
        step();
    endtask

    task automatic test_jump();
        // load-use outranks jump
        clear_inputs();
        jump_id = 1'b1; memread_ex = 1'b1; rt_ex = 5'd4; rt_id = 5'd4; use_rt_id = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble} !== 4'b0101) begin
            errors++;
            $display("FAIL lu_over_jump: got %b expected 0101", {pc_write, ifid_hold, ifid_flush, idex_bubble});
        end
        step();
        exp_stall = exp_stall + 16'd1;
        clear_inputs();
        jump_id = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble} !== 4'b1010) begin
            errors++;
            $display("FAIL jump: got %b expected 1010", {pc_write, ifid_hold, ifid_flush, idex_bubble});
        end
        step();
    endtask

    task automatic test_divide();
        int busy_n = 0, stall_n = 0, done_n = 0, done_at = 0, hold_bad = 0;
        bit exited = 0;
        clear_inputs();
        md_id = 1'b1; md_div_id = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble, md_busy} !== 5'b10000) begin
            errors++;
            $display("FAIL div_issue: got %b expected 10000", {pc_write, ifid_hold, ifid_flush, idex_bubble, md_busy});
        end
        step();
        clear_inputs();
        branch_taken_ex = 1'b1;   // must be ignored while waiting
        for (int i = 0; i < 40 && !exited; i++) begin
            if (md_busy) begin
                busy_n++;
                if (!pc_write) stall_n++;
                if (!ifid_hold || ifid_flush || !idex_bubble) hold_bad++;
                if (md_done) begin
                    done_n++;
                    done_at = busy_n;
                end
                step();
            end else begin
                exited = 1;
            end
        end
        clear_inputs();
        checks++;
        if (!exited) begin
            errors++;
            $display("FAIL div_timeout: busy still %b after 40 cycles, expected release", md_busy);
        end
        checks++;
        if (busy_n != 31 || stall_n != 31) begin
            errors++;
            $display("FAIL div_busy_len: busy=%0d stall=%0d expected 31 31", busy_n, stall_n);
        end
        checks++;
        if (done_n != 1 || done_at != 31) begin
            errors++;
            $display("FAIL div_done: pulses=%0d at=%0d expected 1 at 31", done_n, done_at);
        end
        checks++;
        if (hold_bad != 0) begin
            errors++;
            $display("FAIL div_wait_ctrl: bad cycles=%0d expected 0", hold_bad);
        end
        exp_stall = exp_stall + 16'd31;
        #1;
        checks++;
        if (stall_cnt !== exp_stall || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL div_after: stall=%0d pc_write=%b expected %0d 1", stall_cnt, pc_write, exp_stall);
        end
        step();
    endtask

    task automatic test_mul_reset();
        int seen = 0;
        clear_inputs();
        md_id = 1'b1; md_div_id = 1'b0;
        step();                 // first MD_WAIT cycle
        clear_inputs();
        step();                 // second MD_WAIT cycle
        checks++;
        if (md_busy !== 1'b1) begin
            errors++;
            $display("FAIL mul_busy: got %b expected 1", md_busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_hold, ifid_flush, idex_bubble} !== 4'b0011) begin
            errors++;
            $display("FAIL mul_rst_ctrl: got %b expected 0011", {pc_write, ifid_hold, ifid_flush, idex_bubble});
        end
        step();
        rst = 1'b0;
        checks++;
        if ({md_busy, md_done, stall_cnt} !== 18'd0) begin
            errors++;
            $display("FAIL mul_rst_regs: busy=%b done=%b stall=%0h expected 0 0 0", md_busy, md_done, stall_cnt);
        end
        exp_stall = 16'd0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (md_busy || md_done || !pc_write) seen++;
            step();
        end
        checks++;
        if (seen != 0 || stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL mul_abandoned: activity=%0d stall=%0d expected 0 0", seen, stall_cnt);
        end
    endtask

    task automatic test_saturate();
        clear_inputs();
        memread_ex = 1'b1; rt_ex = 5'd8; rs_id = 5'd8; use_rs_id = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_pre: got %0h expected fffe", stall_cnt);
        end
        repeat (70000 - 65534) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: got %0h expected ffff", stall_cnt);
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        exp_stall = 16'd0;
        test_reset();
        test_load_use();
        test_branch_priority();
        test_jump();
        test_divide();
        test_mul_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: EX-occupancy cycles of a multiply (range 2..63).
REQ-002 Parameter DIV_CYCLES, default 32: EX-occupancy cycles of a divide (range 2..63).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rs_id, rt_id  in  5 each  source register numbers of the instruction in ID.
REQ-006 use_rs_id, use_rt_id  in  1 each  ID instruction actually reads rs / rt.
REQ-007 memread_ex  in  1  EX instruction is a load.
REQ-008 rt_ex  in  5  destination register of the EX load.
REQ-009 md_id  in  1  ID instruction is a mult/div.
REQ-010 md_div_id  in  1  with md_id, selects divide (1) or multiply (0).
REQ-011 branch_taken_ex  in  1  branch resolved taken in EX.
REQ-012 jump_id  in  1  ID instruction is j/jal/jr.
REQ-013 pc_write  out  1  PC may update this cycle.
REQ-014 ifid_hold  out  1  IF/ID register keeps its contents (the loaduse input of the IF/ID register).
REQ-015 ifid_flush  out  1  IF/ID contents are invalidated (the xiaoc input of the IF/ID register).
REQ-016 idex_bubble  out  1  ID/EX loads a NOP.
REQ-017 md_busy  out  1  multi-cycle unit occupied (registered).
REQ-018 md_done  out  1  one-cycle pulse on the final cycle of the MD operation (registered).
REQ-019 stall_cnt  out  16  saturating count of front-end stall cycles (registered).

Function
REQ-020 FSM states: RUN, MD_WAIT; encoding 1'b0/1'b1.
REQ-021 lu = memread_ex & (rt_ex != 0) & ((use_rs_id & rs_id == rt_ex) | (use_rt_id & rt_id == rt_ex)).
REQ-022 RUN priority, highest first: branch_taken_ex, lu, jump_id, md_id, none.
REQ-023 RUN, branch_taken_ex: pc_write=1, ifid_hold=0, ifid_flush=1, idex_bubble=1; lu, jump_id, md_id ignored.
REQ-024 RUN, lu: pc_write=0, ifid_hold=1, ifid_flush=0, idex_bubble=1; md_id does not start the unit.
REQ-025 RUN, jump_id: pc_write=1, ifid_flush=1, ifid_hold=0, idex_bubble=0.
REQ-026 RUN, md_id with no higher-priority event: outputs as none case; next state MD_WAIT; counter loads (md_div_id ? DIV_CYCLES : MUL_CYCLES) - 2.
REQ-027 RUN, none: pc_write=1, all other control outputs 0.
REQ-028 MD_WAIT: pc_write=0, ifid_hold=1, ifid_flush=0, idex_bubble=1, md_busy=1; branch_taken_ex, lu, jump_id ignored.
REQ-029 MD_WAIT: counter decrements each cycle; when counter==0, md_done=1 that cycle and next state RUN.
REQ-030 Total front-end stall for one MD op is exactly N-1 cycles after issue (N = cycles parameter); md_busy high exactly N-1 cycles.
REQ-031 Control outputs (REQ-023..028) are combinational from state and inputs, zero-latency.
REQ-032 stall_cnt increments by 1 each cycle pc_write==0 and rst==0; holds at 16'hFFFF.
REQ-033 Counter width 6 bits; no wrap-around reachable within the parameter range.

Reset
REQ-034 rst high at a rising edge: state=RUN, counter=0, md_busy=0, md_done=0, stall_cnt=0, regardless of current state (including mid MD_WAIT; the MD op is abandoned).
REQ-035 While rst is high: pc_write=0, ifid_hold=0, ifid_flush=1, idex_bubble=1.
REQ-036 First cycle after rst deasserts behaves as RUN with no history.

Structure
REQ-037 Shared package holds the state encoding constants and MUL_CYCLES/DIV_CYCLES defaults, used by the EX-stage mult/div unit.
REQ-038 One sub-module, md_counter (load, decrement, zero flag); hazard decode and FSM stay in hazard_ctrl.

Verification
REQ-039 memread_ex=1, rt_ex=8, rs_id=8, use_rs_id=1 -> same cycle pc_write=0, ifid_hold=1, idex_bubble=1; stall_cnt +1.
REQ-040 Same as REQ-039 but rt_ex=0 -> pc_write=1, no hold, no bubble.
REQ-041 branch_taken_ex=1 with lu and md_id both true -> ifid_flush=1, idex_bubble=1, pc_write=1, state stays RUN.
REQ-042 md_id=1, md_div_id=1, defaults -> md_busy high 31 cycles, md_done on 31st, pc_write=0 for 31 cycles, then RUN.
REQ-043 md_id=1, md_div_id=0, rst asserted on 2nd MD_WAIT cycle -> next cycle state RUN, md_busy=0, md_done never pulses, stall_cnt=0.
REQ-044 Force 70000 consecutive lu cycles -> stall_cnt saturates at 16'hFFFF.
